muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the next-generation pipelined core.
- Sits beside the ALU in the EX stage.
- The hazard logic stalls IF/ID/EX while `busy` is high, and also when MFHI/MFLO is decoded while `busy` is high.
- Datapath width is parametrised. Signed and unsigned MULT/DIV are supported, plus MTHI/MTLO and pipeline flush cancellation.

Parameters:
- WIDTH, 32: operand, HI and LO width. Must be even and ≥ 4.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  issue request, sampled each rising edge
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op
- a  in  WIDTH  rs operand (multiplicand / dividend / MT source)
- b  in  WIDTH  rt operand (multiplier / divisor)
- flush  in  1  cancel the in-flight operation
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV
- dz  out  1  sticky flag: last DIV/DIVU had a zero divisor
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: all outputs are 0 (`busy`, `done`, `dz`, `hi`, `lo`); FSM goes to IDLE. Reset mid-operation aborts the operation and clears HI/LO.
- FSM states:
  - IDLE → RUN on an edge with `start` = 1 and `op` ∈ {000..011}. On that edge: latch operand magnitudes (abs value for signed ops), latch result-sign bits, counter := 0, `busy` := 1, `dz` := 0.
  - RUN: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide). After WIDTH steps → FIX.
  - FIX: one cycle of sign correction, then write HI/LO. `busy` := 0, `done` := 1 for exactly one cycle, → IDLE.
  - Latency: HI/LO are updated on the edge WIDTH+1 edges after the accept edge. `busy` is high for exactly WIDTH+1 cycles.
- MTHI/MTLO: accepted only in IDLE with `start` = 1. Writes HI/LO := `a` on that edge. No `busy`, no `done`.
- `start` while `busy`: ignored; the in-flight operation is unaffected.
- `op` 11x: ignored.
- Multiply results:
  - `{hi, lo}` = full 2·WIDTH-bit product.
  - Signed product is two's-complement exact, including MIN × MIN = 2^(2·WIDTH−2).
- Divide results:
  - `lo` = quotient, truncated toward zero.
  - `hi` = remainder, which takes the sign of the dividend.
- Divide by zero (`b` = 0):
  - Still runs the full WIDTH+1 cycles.
  - Result: `lo` = all ones, `hi` = `a` unchanged, `dz` := 1.
- Signed overflow (DIV, `a` = MIN, `b` = −1): `lo` = MIN, `hi` = 0, `dz` = 0.
- `flush`:
  - When `flush` = 1 on any edge with `busy` = 1: → IDLE, `busy` := 0, no `done`, HI/LO and `dz` unchanged.
  - When `flush` and `start` are both 1 in IDLE: `flush` wins; nothing is accepted, including MTHI/MTLO.
- `hi`/`lo` are not updated during RUN; intermediate values are held in internal registers only.

Test Plan:
1. WIDTH = 32, MULT `a` = 0xFFFFFFFD (−3), `b` = 5 → `busy` high 33 cycles; then `done` pulse, `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1.
2. MULTU `a` = `b` = 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
3. DIV `a` = 0xFFFFFFF9 (−7), `b` = 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. DIVU `a` = 7, `b` = 0 → `lo` = 0xFFFFFFFF, `hi` = 7, `dz` = 1.
4. DIV `a` = 0x80000000, `b` = 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0. Repeat with MULT MIN × MIN → `hi` = 0x40000000, `lo` = 0.
5. MTHI 0x1234 then MTLO 0x5678 (idle); MULTU 3 × 4; assert `flush` 10 cycles in → `busy` low next cycle, no `done`, `hi` = 0x1234, `lo` = 0x5678. A `start` issued during `busy` is ignored.
6. WIDTH = 8, CNT_W = 4: DIV 0x9C (−100) / 7 → 9 cycles `busy`, `lo` = 0xF2 (−14), `hi` = 0xFE (−2). Assert `reset` mid-RUN → all outputs 0 on the next edge.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] acc_reg;   // product high half / partial remainder
  logic [WIDTH-1:0] mq_reg;    // multiplier / dividend shifting out, low product / quotient shifting in
  logic [WIDTH-1:0] mb_reg;    // multiplicand / divisor magnitude
  logic             is_div_reg;
  logic             neg_res_reg;
  logic             neg_rem_reg;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    a_neg     = op[0] & a[WIDTH-1];
    b_neg     = op[0] & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    mul_sum   = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, mb_reg} : {(WIDTH+1){1'b0}});
    div_shift = {acc_reg, mq_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mb_reg};
    div_ok    = ~div_diff[WIDTH];
    prod_fix  = neg_res_reg ? (~{acc_reg, mq_reg} + 1'b1) : {acc_reg, mq_reg};
    quo_fix   = neg_res_reg ? (~mq_reg + 1'b1) : mq_reg;
    rem_fix   = neg_rem_reg ? (~acc_reg + 1'b1) : acc_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mq_reg      <= '0;
      mb_reg      <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dz          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !flush) begin
            if (!op[2]) begin
              state_reg   <= RUN;
              busy        <= 1'b1;
              dz          <= 1'b0;
              cnt_reg     <= '0;
              acc_reg     <= '0;
              mq_reg      <= a_mag;
              mb_reg      <= b_mag;
              is_div_reg  <= op[1];
              neg_res_reg <= a_neg ^ b_neg;
              neg_rem_reg <= a_neg;
            end else if (!op[1]) begin
              if (op[0]) lo <= a;
              else       hi <= a;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            if (is_div_reg) begin
              acc_reg <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              mq_reg  <= {mq_reg[WIDTH-2:0], div_ok};
            end else begin
              acc_reg <= mul_sum[WIDTH:1];
              mq_reg  <= {mul_sum[0], mq_reg[WIDTH-1:1]};
            end
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= FIX;
          end
        end
        FIX: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (is_div_reg) begin
              // Zero divisor leaves the dividend magnitude in acc, so rem_fix restores a.
              hi <= rem_fix;
              if (mb_reg == '0) begin
                lo <= '1;
                dz <= 1'b1;
              end else begin
                lo <= quo_fix;
              end
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: one 32-bit and one 8-bit instance,
// hand-computed results, busy-length, done pulse, flush and reset checks.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset32, start32, flush32, busy32, done32, dz32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        reset8, start8, flush8, busy8, done8, dz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) u_dut32 (
    .clk(clk), .reset(reset32), .start(start32), .op(op32), .a(a32), .b(b32),
    .flush(flush32), .busy(busy32), .done(done32), .dz(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .reset(reset8), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .dz(dz8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic s, input logic [2:0] o,
                       input logic [31:0] av, input logic [31:0] bv);
    if (w8) begin
      start8 = s; op8 = o; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start32 = s; op32 = o; a32 = av; b32 = bv;
    end
  endtask

  function automatic logic cur_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz, input string tag);
    int cyc;
    @(negedge clk);
    drive(w8, 1'b1, o, av, bv);
    @(negedge clk);
    drive(w8, 1'b0, 3'b111, 32'h0, 32'h0);
    cyc = 0;
    while (cur_busy(w8) && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, 64'(cyc), w8 ? 64'd9 : 64'd33);
    check({tag, "_done"}, {63'b0, w8 ? done8 : done32}, 64'd1);
    check({tag, "_hi"}, w8 ? {56'b0, hi8} : {32'b0, hi32}, {32'b0, ehi});
    check({tag, "_lo"}, w8 ? {56'b0, lo8} : {32'b0, lo32}, {32'b0, elo});
    check({tag, "_dz"}, {63'b0, w8 ? dz8 : dz32}, {63'b0, edz});
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'b0, w8 ? done8 : done32}, 64'd0);
    $display("%s: hi=%h lo=%h dz=%0d cycles=%0d", tag,
             w8 ? {24'b0, hi8} : hi32, w8 ? {24'b0, lo8} : lo32, w8 ? dz8 : dz32, cyc);
  endtask

  initial begin
    int  cyc;
    bit  seen_done;
    reset32 = 1'b1; start32 = 1'b0; flush32 = 1'b0; op32 = 3'b111; a32 = '0; b32 = '0;
    reset8  = 1'b1; start8  = 1'b0; flush8  = 1'b0; op8  = 3'b111; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy32}, 64'd0);
    check("rst_done", {63'b0, done32}, 64'd0);
    check("rst_dz", {63'b0, dz32}, 64'd0);
    check("rst_hi", {32'b0, hi32}, 64'd0);
    check("rst_lo", {32'b0, lo32}, 64'd0);
    $display("reset: busy=%0d hi=%h lo=%h", busy32, hi32, lo32);
    reset32 = 1'b0;
    reset8  = 1'b0;

    run_op(1'b0, 3'b001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, "mult_m3x5");
    run_op(1'b0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
    run_op(1'b0, 3'b011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7d2");
    run_op(1'b0, 3'b010, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1, "divu_7d0");
    run_op(1'b0, 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf");
    run_op(1'b0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minmin");
    run_op(1'b0, 3'b011, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, "div_100dm7");
    run_op(1'b0, 3'b010, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0, "divu_max");
    run_op(1'b0, 3'b011, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, "div_m5d0");

    // A start (MTLO) during busy must not disturb the running MULTU.
    @(negedge clk); drive(1'b0, 1'b1, 3'b000, 32'd3, 32'd4);
    @(negedge clk); drive(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    drive(1'b0, 1'b1, 3'b101, 32'hDEAD, 32'h0);
    @(negedge clk); drive(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);
    cyc = 0;
    while (busy32 && cyc < 100) begin cyc++; @(negedge clk); end
    check("busy_start_lo", {32'b0, lo32}, 64'd12);
    check("busy_start_hi", {32'b0, hi32}, 64'd0);
    $display("start_during_busy: hi=%h lo=%h", hi32, lo32);

    @(negedge clk); drive(1'b0, 1'b1, 3'b100, 32'h1234, 32'h0);
    @(negedge clk); drive(1'b0, 1'b1, 3'b101, 32'h5678, 32'h0);
    @(negedge clk); drive(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);
    check("mthi", {32'b0, hi32}, 64'h1234);
    check("mtlo", {32'b0, lo32}, 64'h5678);
    check("mt_busy", {63'b0, busy32}, 64'd0);
    $display("mthi/mtlo: hi=%h lo=%h", hi32, lo32);

    // flush beats start in IDLE, even for MTHI.
    flush32 = 1'b1; drive(1'b0, 1'b1, 3'b100, 32'hBEEF, 32'h0);
    @(negedge clk); flush32 = 1'b0; drive(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);
    check("flush_idle_hi", {32'b0, hi32}, 64'h1234);
    $display("flush_idle: hi=%h", hi32);

    drive(1'b0, 1'b1, 3'b000, 32'd3, 32'd4);
    @(negedge clk); drive(1'b0, 1'b0, 3'b111, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    check("flush_pre_busy", {63'b0, busy32}, 64'd1);
    flush32 = 1'b1;
    @(negedge clk); flush32 = 1'b0;
    check("flush_busy", {63'b0, busy32}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done32) seen_done = 1'b1;
      @(negedge clk);
    end
    check("flush_no_done", {63'b0, seen_done}, 64'd0);
    check("flush_hi", {32'b0, hi32}, 64'h1234);
    check("flush_lo", {32'b0, lo32}, 64'h5678);
    $display("flush_run: busy=%0d hi=%h lo=%h", busy32, hi32, lo32);

    run_op(1'b1, 3'b011, 32'h9C, 32'h07, 32'hFE, 32'hF2, 1'b0, "div8_m100d7");
    run_op(1'b1, 3'b010, 32'h05, 32'h00, 32'h05, 32'hFF, 1'b1, "divu8_5d0");

    @(negedge clk); drive(1'b1, 1'b1, 3'b001, 32'h0B, 32'h0D);
    @(negedge clk); drive(1'b1, 1'b0, 3'b111, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    reset8 = 1'b1;
    @(negedge clk);
    check("rst8_busy", {63'b0, busy8}, 64'd0);
    check("rst8_done", {63'b0, done8}, 64'd0);
    check("rst8_dz", {63'b0, dz8}, 64'd0);
    check("rst8_hi", {56'b0, hi8}, 64'd0);
    check("rst8_lo", {56'b0, lo8}, 64'd0);
    $display("reset8_mid_run: busy=%0d dz=%0d hi=%h lo=%h", busy8, dz8, hi8, lo8);
    reset8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
